// File: rtl/adc_sensor_filter_pkg.sv
// adc_sensor_filter_pkg
// Shared definitions for the ADC sensor conditioning slice:
//   - raw ADC word width and the bit range that carries real data
//   - FSM state encodings used by the top level
//   - level_out_of_band(): hysteresis window test for the dial level
package adc_sensor_filter_pkg;

  localparam int ADC_RAW_W    = 12;
  localparam int ADC_DATA_MSB = 11;
  localparam int ADC_DATA_LSB = 4;
  localparam int SAMPLE_W     = ADC_DATA_MSB - ADC_DATA_LSB + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_UPDATE  = 2'd2;
  localparam logic [1:0] S_PUBLISH = 2'd3;

  // True when f lies outside the band [L*16 - hyst, L*16 + 15 + hyst].
  // Bounds are formed in 10-bit signed so that L=0 minus hyst goes negative
  // instead of wrapping; the edge levels simply have no bound on that side.
  function automatic logic level_out_of_band(input logic [3:0] level,
                                             input logic [7:0] f,
                                             input logic [7:0] hyst);
    logic signed [9:0] base;
    logic signed [9:0] lo;
    logic signed [9:0] hi;
    logic signed [9:0] fv;
    base = signed'({2'b00, level, 4'b0000});
    lo   = base - signed'({2'b00, hyst});
    hi   = base + 10'sd15 + signed'({2'b00, hyst});
    fv   = signed'({2'b00, f});
    return ((level != 4'd0) && (fv < lo)) || ((level != 4'd15) && (fv > hi));
  endfunction

endpackage

// File: rtl/adc_sensor_filter_if.sv
// adc_sensor_filter_if
// Bundles the raw ADC channel words and the conditioned outputs.
//   master : the filter (reads raw values, drives filtered results)
//   slave  : the ADC/game side (drives raw values, reads filtered results)
interface adc_sensor_filter_if;
  import adc_sensor_filter_pkg::*;

  logic [ADC_RAW_W-1:0] dial_value;
  logic [ADC_RAW_W-1:0] cds_value;
  logic [7:0]           dial_filt;
  logic [7:0]           cds_filt;
  logic [3:0]           dial_level;
  logic                 is_dark;
  logic                 filt_valid;
  logic                 level_changed;

  modport master (
    input  dial_value, cds_value,
    output dial_filt, cds_filt, dial_level, is_dark, filt_valid, level_changed
  );

  modport slave (
    output dial_value, cds_value,
    input  dial_filt, cds_filt, dial_level, is_dark, filt_valid, level_changed
  );

endinterface

// File: rtl/adc_sensor_filter_moving_avg_ch.sv
// moving_avg_ch
// One channel of a 2^AVG_LOG2-deep moving average.
//   clk, rst_n : clock and async active-low reset
//   sample     : new 8-bit sample
//   load       : one-cycle strobe that folds sample into the average
//   avg        : current average (truncated sum)
// The first load after reset fills the whole window with that sample so the
// output jumps straight to it instead of ramping up from zero.
module moving_avg_ch
  import adc_sensor_filter_pkg::*;
#(
  parameter int AVG_LOG2 = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                load,
  output logic [SAMPLE_W-1:0] avg
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = SAMPLE_W + AVG_LOG2;

  logic [SAMPLE_W-1:0] buf_q [DEPTH];
  logic [SAMPLE_W-1:0] buf_d [DEPTH];
  logic [AVG_LOG2-1:0] ptr_q, ptr_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic                primed_q, primed_d;

  // Running sum: add the newest sample, drop the oldest. Intermediate
  // wrap in the subtraction cancels out because the true sum always fits.
  always_comb begin
    buf_d    = buf_q;
    ptr_d    = ptr_q;
    sum_d    = sum_q;
    primed_d = primed_q;
    if (load) begin
      if (!primed_q) begin
        for (int i = 0; i < DEPTH; i++) buf_d[i] = sample;
        sum_d    = SUM_W'(sample) << AVG_LOG2;
        primed_d = 1'b1;
      end else begin
        sum_d        = sum_q + SUM_W'(sample) - SUM_W'(buf_q[ptr_q]);
        buf_d[ptr_q] = sample;
        ptr_d        = ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      ptr_q    <= '0;
      sum_q    <= '0;
      primed_q <= 1'b0;
    end else begin
      buf_q    <= buf_d;
      ptr_q    <= ptr_d;
      sum_q    <= sum_d;
      primed_q <= primed_d;
    end
  end

  // Exposes the post-load value so the publish registers can capture the
  // fresh average on the same edge that updates the sum.
  assign avg = sum_d[SUM_W-1:AVG_LOG2];

endmodule

// File: rtl/adc_sensor_filter.sv
// adc_sensor_filter
// Samples the dial (Ch0) and CDS (Ch1) ADC words on a fixed tick, averages
// each channel, and derives a hysteretic 16-step dial level and dark flag.
//   clk, rst_n : 50 MHz clock, async active-low reset
//   bus        : master side of adc_sensor_filter_if (raw in, filtered out)
// Sequence per tick: IDLE -> CAPTURE -> UPDATE -> PUBLISH -> IDLE.
module adc_sensor_filter
  import adc_sensor_filter_pkg::*;
#(
  parameter int         SAMPLE_DIV = 500000,
  parameter int         AVG_LOG2   = 3,
  parameter logic [7:0] DARK_ON    = 8'd60,
  parameter logic [7:0] DARK_OFF   = 8'd80,
  parameter logic [7:0] LEVEL_HYST = 8'd4
) (
  input logic                 clk,
  input logic                 rst_n,
  adc_sensor_filter_if.master bus
);

  localparam int CNT_W = $clog2(SAMPLE_DIV);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tick;
  logic [1:0]          state_q, state_d;
  logic [SAMPLE_W-1:0] dial_s_q, dial_s_d, cds_s_q, cds_s_d;
  logic [SAMPLE_W-1:0] dial_avg, cds_avg;
  logic [7:0]          dial_filt_q, dial_filt_d, cds_filt_q, cds_filt_d;
  logic [3:0]          dial_level_q, dial_level_d;
  logic                is_dark_q, is_dark_d;
  logic                filt_valid_q, filt_valid_d;
  logic                level_changed_q, level_changed_d;
  logic                published_q, published_d;
  logic                unused_lsbs;

  assign unused_lsbs = ^{bus.dial_value[ADC_DATA_LSB-1:0], bus.cds_value[ADC_DATA_LSB-1:0]};
  assign tick        = (cnt_q == CNT_W'(SAMPLE_DIV - 1));

  // Free-running sample divider, the FSM sequencing and input capture.
  always_comb begin
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    state_d  = state_q;
    dial_s_d = dial_s_q;
    cds_s_d  = cds_s_q;
    case (state_q)
      S_IDLE:    if (tick) state_d = S_CAPTURE;
      S_CAPTURE: begin
        dial_s_d = bus.dial_value[ADC_DATA_MSB:ADC_DATA_LSB];
        cds_s_d  = bus.cds_value[ADC_DATA_MSB:ADC_DATA_LSB];
        state_d  = S_UPDATE;
      end
      S_UPDATE:  state_d = S_PUBLISH;
      default:   state_d = S_IDLE;
    endcase
  end

  moving_avg_ch #(.AVG_LOG2(AVG_LOG2)) u_dial_avg (
    .clk    (clk),
    .rst_n  (rst_n),
    .sample (dial_s_q),
    .load   (state_q == S_UPDATE),
    .avg    (dial_avg)
  );

  moving_avg_ch #(.AVG_LOG2(AVG_LOG2)) u_cds_avg (
    .clk    (clk),
    .rst_n  (rst_n),
    .sample (cds_s_q),
    .load   (state_q == S_UPDATE),
    .avg    (cds_avg)
  );

  // Publish registers load on the edge that enters S_PUBLISH, so every
  // output and the filt_valid pulse are visible together during S_PUBLISH,
  // three cycles after the tick. The first publish always takes f[7:4].
  always_comb begin
    dial_filt_d     = dial_filt_q;
    cds_filt_d      = cds_filt_q;
    dial_level_d    = dial_level_q;
    is_dark_d       = is_dark_q;
    filt_valid_d    = 1'b0;
    level_changed_d = 1'b0;
    published_d     = published_q;
    if (state_q == S_UPDATE) begin
      dial_filt_d = dial_avg;
      cds_filt_d  = cds_avg;
      if (!published_q || level_out_of_band(dial_level_q, dial_avg, LEVEL_HYST))
        dial_level_d = dial_avg[7:4];
      level_changed_d = (dial_level_d != dial_level_q);
      if (cds_avg < DARK_ON)
        is_dark_d = 1'b1;
      else if (cds_avg > DARK_OFF)
        is_dark_d = 1'b0;
      filt_valid_d = 1'b1;
      published_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q           <= '0;
      state_q         <= S_IDLE;
      dial_s_q        <= '0;
      cds_s_q         <= '0;
      dial_filt_q     <= '0;
      cds_filt_q      <= '0;
      dial_level_q    <= '0;
      is_dark_q       <= 1'b0;
      filt_valid_q    <= 1'b0;
      level_changed_q <= 1'b0;
      published_q     <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      state_q         <= state_d;
      dial_s_q        <= dial_s_d;
      cds_s_q         <= cds_s_d;
      dial_filt_q     <= dial_filt_d;
      cds_filt_q      <= cds_filt_d;
      dial_level_q    <= dial_level_d;
      is_dark_q       <= is_dark_d;
      filt_valid_q    <= filt_valid_d;
      level_changed_q <= level_changed_d;
      published_q     <= published_d;
    end
  end

  assign bus.dial_filt     = dial_filt_q;
  assign bus.cds_filt      = cds_filt_q;
  assign bus.dial_level    = dial_level_q;
  assign bus.is_dark       = is_dark_q;
  assign bus.filt_valid    = filt_valid_q;
  assign bus.level_changed = level_changed_q;

endmodule

// File: tb/tb_adc_sensor_filter.sv
// tb_adc_sensor_filter
// Directed bench for adc_sensor_filter with SAMPLE_DIV=4, AVG_LOG2=3.
// Each scenario task drives stimulus and compares against hand-computed values.
module tb_adc_sensor_filter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  adc_sensor_filter_if bus ();

  adc_sensor_filter #(
    .SAMPLE_DIV (4),
    .AVG_LOG2   (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits (bounded) for the next filt_valid, sampled on falling edges.
  // cycles = number of falling edges taken, found = pulse seen.
  task automatic wait_publish(output int cycles, output bit found);
    cycles = 0;
    found  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cycles++;
      if (bus.filt_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL publish_timeout got no filt_valid within %0d cycles required a pulse", cycles);
    end
  endtask

  // Holds reset for two cycles with the given inputs, releasing on a falling edge.
  task automatic reset_with(input logic [11:0] dial, input logic [11:0] cds);
    @(negedge clk);
    rst_n          = 1'b0;
    bus.dial_value = dial;
    bus.cds_value  = cds;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.dial_value = 12'h000;
    bus.cds_value  = 12'h000;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.dial_filt !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_dial_filt got %h required 00", bus.dial_filt);
    end
    checks++;
    if ({bus.cds_filt, bus.dial_level, bus.is_dark} !== 13'h0) begin
      errors++;
      $display("[TB] FAIL reset_cds_level_dark got %h/%h/%b required 00/0/0",
               bus.cds_filt, bus.dial_level, bus.is_dark);
    end
    checks++;
    if ({bus.filt_valid, bus.level_changed} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_pulses got %b%b required 00", bus.filt_valid, bus.level_changed);
    end
  endtask

  task automatic test_first_publish();
    int cyc;
    bit ok;
    reset_with(12'hA50, 12'h5A0);
    wait_publish(cyc, ok);
    if (ok) begin
      checks++;
      if (cyc != 6) begin
        errors++;
        $display("[TB] FAIL first_latency got %0d required 6", cyc);
      end
      checks++;
      if (bus.dial_filt !== 8'hA5) begin
        errors++;
        $display("[TB] FAIL first_dial_filt got %h required a5", bus.dial_filt);
      end
      checks++;
      if (bus.dial_level !== 4'd10 || bus.level_changed !== 1'b1) begin
        errors++;
        $display("[TB] FAIL first_level got %0d chg %b required 10 chg 1",
                 bus.dial_level, bus.level_changed);
      end
      checks++;
      if (bus.cds_filt !== 8'h5A || bus.is_dark !== 1'b0) begin
        errors++;
        $display("[TB] FAIL first_cds got %h dark %b required 5a dark 0", bus.cds_filt, bus.is_dark);
      end
    end
  endtask

  task automatic test_step_response();
    int cyc;
    bit ok;
    logic [7:0] exp;
    reset_with(12'h100, 12'h5A0);
    wait_publish(cyc, ok);
    checks++;
    if (bus.dial_filt !== 8'h10) begin
      errors++;
      $display("[TB] FAIL step_prime got %h required 10", bus.dial_filt);
    end
    bus.dial_value = 12'h900;
    for (int k = 1; k <= 9; k++) begin
      wait_publish(cyc, ok);
      exp = (k <= 8) ? 8'(8'h10 + 16 * k) : 8'h90;
      checks++;
      if (bus.dial_filt !== exp) begin
        errors++;
        $display("[TB] FAIL step_sample_%0d got %h required %h", k, bus.dial_filt, exp);
      end
    end
  endtask

  task automatic test_level_hysteresis();
    int cyc;
    bit ok;
    int changes;
    reset_with(12'h500, 12'h5A0);
    wait_publish(cyc, ok);
    checks++;
    if (bus.dial_level !== 4'd5 || bus.level_changed !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hyst_start got %0d chg %b required 5 chg 1", bus.dial_level, bus.level_changed);
    end
    bus.dial_value = 12'h4E0;
    changes = 0;
    for (int k = 0; k < 10; k++) begin
      wait_publish(cyc, ok);
      if (bus.level_changed === 1'b1) changes++;
      checks++;
      if (bus.dial_level !== 4'd5) begin
        errors++;
        $display("[TB] FAIL hyst_hold_%0d got %0d required 5", k, bus.dial_level);
      end
    end
    checks++;
    if (changes != 0) begin
      errors++;
      $display("[TB] FAIL hyst_hold_changes got %0d required 0", changes);
    end
    bus.dial_value = 12'h4B0;
    changes = 0;
    for (int k = 0; k < 10; k++) begin
      wait_publish(cyc, ok);
      if (bus.level_changed === 1'b1) changes++;
    end
    checks++;
    if (changes != 1) begin
      errors++;
      $display("[TB] FAIL hyst_drop_changes got %0d required 1", changes);
    end
    checks++;
    if (bus.dial_level !== 4'd4 || bus.dial_filt !== 8'h4B) begin
      errors++;
      $display("[TB] FAIL hyst_drop_level got %0d filt %h required 4 filt 4b",
               bus.dial_level, bus.dial_filt);
    end
  endtask

  task automatic test_dark();
    int cyc;
    bit ok;
    logic [11:0] cds_in   [4];
    logic [7:0]  cds_exp  [4];
    logic        dark_exp [4];
    cds_in   = '{12'h5A0, 12'h320, 12'h460, 12'h550};
    cds_exp  = '{8'd90, 8'd50, 8'd70, 8'd85};
    dark_exp = '{1'b0, 1'b1, 1'b1, 1'b0};
    reset_with(12'h200, cds_in[0]);
    for (int s = 0; s < 4; s++) begin
      bus.cds_value = cds_in[s];
      for (int k = 0; k < 10; k++) wait_publish(cyc, ok);
      checks++;
      if (bus.cds_filt !== cds_exp[s] || bus.is_dark !== dark_exp[s]) begin
        errors++;
        $display("[TB] FAIL dark_step_%0d got %0d dark %b required %0d dark %b",
                 s, bus.cds_filt, bus.is_dark, cds_exp[s], dark_exp[s]);
      end
    end
  endtask

  task automatic test_reset_midcycle();
    int cyc;
    bit ok;
    reset_with(12'hC00, 12'h320);
    wait_publish(cyc, ok);
    bus.dial_value = 12'hE00;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.dial_filt, bus.cds_filt, bus.dial_level, bus.is_dark,
         bus.filt_valid, bus.level_changed} !== 23'h0) begin
      errors++;
      $display("[TB] FAIL midreset_clear got %h/%h/%h/%b/%b/%b required all zero",
               bus.dial_filt, bus.cds_filt, bus.dial_level, bus.is_dark,
               bus.filt_valid, bus.level_changed);
    end
    bus.dial_value = 12'h300;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_publish(cyc, ok);
    checks++;
    if (bus.dial_filt !== 8'h30 || bus.dial_level !== 4'd3) begin
      errors++;
      $display("[TB] FAIL midreset_reprime got %h level %0d required 30 level 3",
               bus.dial_filt, bus.dial_level);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit ok;
    int bad_gaps;
    logic [7:0] prev;
    bus.dial_value = 12'hFF0;
    wait_publish(cyc, ok);
    prev     = bus.dial_filt;
    bad_gaps = 0;
    for (int k = 0; k < 20; k++) begin
      wait_publish(cyc, ok);
      if (cyc != 4) bad_gaps++;
      checks++;
      if (bus.dial_filt < prev) begin
        errors++;
        $display("[TB] FAIL sat_monotonic_%0d got %h required >= %h", k, bus.dial_filt, prev);
      end
      prev = bus.dial_filt;
    end
    checks++;
    if (bad_gaps != 0) begin
      errors++;
      $display("[TB] FAIL sat_pulse_spacing got %0d bad gaps required 0", bad_gaps);
    end
    checks++;
    if (bus.dial_filt !== 8'hFF || bus.dial_level !== 4'd15) begin
      errors++;
      $display("[TB] FAIL sat_final got %h level %0d required ff level 15", bus.dial_filt, bus.dial_level);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    $display("[TB] start");
    test_reset();
    test_first_publish();
    test_step_response();
    test_level_hysteresis();
    test_dark();
    test_reset_midcycle();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
